// File: rtl/shreg_arbiter.sv
// Round-robin shared owner of a WIDTH-bit universal shift register: grant at E0, load at E1, N shifts at E1..EN.
// Requesters hold req until their done pulse; losers stay pending. At least one IDLE cycle separates operations.
module shreg_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [CNTW-1:0]  cnt0,
  input  logic [CNTW-1:0]  cnt1,
  input  logic             sin,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_SHL  = 2'd1;
  localparam logic [1:0] CMD_SHR  = 2'd2;
  localparam logic [1:0] CMD_ROL  = 2'd3;

  logic [1:0]       state;
  logic             ptr;
  logic [1:0]       op_cmd;
  logic [WIDTH-1:0] op_din;
  logic [CNTW-1:0]  rem;
  logic             win;
  logic [WIDTH-1:0] q_next;

  // The pointer only matters when both requesters are asking at once.
  always_comb begin
    win = (req == 2'b11) ? ptr : req[1];
  end

  always_comb begin
    q_next = q;
    case (op_cmd)
      CMD_SHL:  q_next = {q[WIDTH-2:0], sin};
      CMD_SHR:  q_next = {sin, q[WIDTH-1:1]};
      CMD_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      default:  q_next = op_din;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt    <= 2'b00;
      op_cmd <= CMD_LOAD;
      op_din <= '0;
      rem    <= '0;
      q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt    <= win ? 2'b10 : 2'b01;
            op_cmd <= win ? cmd1 : cmd0;
            op_din <= win ? din1 : din0;
            rem    <= win ? cnt1 : cnt0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (op_cmd == CMD_LOAD) begin
            q     <= op_din;
            state <= DONE;
          end else if (rem == '0) begin
            state <= DONE;
          end else begin
            q   <= q_next;
            rem <= rem - CNTW'(1);
            if (rem == CNTW'(1)) state <= DONE;
          end
        end
        DONE: begin
          gnt   <= 2'b00;
          ptr   <= ~gnt[1];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == EXEC) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shreg_arbiter.sv
// Directed bench for shreg_arbiter: reset, load, shifts, rotate, zero count, contention, reset mid-operation.
module tb_shreg_arbiter;
  localparam int WIDTH = 4;
  localparam int CNTW  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       cmd0 = '0, cmd1 = '0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic [CNTW-1:0]  cnt0 = '0, cnt1 = '0;
  logic             sin = 1'b0;
  logic [1:0]       gnt;
  logic             busy, done;
  logic [WIDTH-1:0] q;

  int checks = 0;
  int errors = 0;

  shreg_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .din0(din0), .din1(din1), .cnt0(cnt0), .cnt1(cnt1), .sin(sin),
    .gnt(gnt), .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eq, input logic [1:0] eg,
                         input logic eb, input logic ed);
    check({tag, "_q"},    8'(q),    8'(eq));
    check({tag, "_gnt"},  8'(gnt),  8'(eg));
    check({tag, "_busy"}, 8'(busy), 8'(eb));
    check({tag, "_done"}, 8'(done), 8'(ed));
  endtask

  // Raise req and check the grant edge E0; q must still show its previous value.
  task automatic start(input string tag, input logic [1:0] r, input logic [3:0] prev_q,
                       input logic [1:0] eg);
    req = r;
    tick();
    chk_out({tag, "_e0"}, prev_q, eg, 1'b1, 1'b0);
  endtask

  // Expected q after Ek is seq nibble k-1; done on the last one, then back to idle.
  task automatic exec_seq(input string tag, input int n, input logic [1:0] eg,
                          input logic [27:0] seq);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk_out($sformatf("%s_e%0d", tag, k), seq[4*(k-1) +: 4], eg, 1'b1, k == n);
    end
    req = 2'b00;
    tick();
    chk_out({tag, "_idle"}, seq[4*(n-1) +: 4], 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      req  = 2'($urandom);
      cmd0 = 2'($urandom); cmd1 = 2'($urandom);
      din0 = 4'($urandom); din1 = 4'($urandom);
      cnt0 = 3'($urandom); cnt1 = 3'($urandom);
      sin  = 1'($urandom);
      tick();
      chk_out("rst_hold", 4'b0000, 2'b00, 1'b0, 1'b0);
    end
    req = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // Load by requester 0
    cmd0 = 2'b00; din0 = 4'b1010;
    start("load", 2'b01, 4'b0000, 2'b01);
    exec_seq("load", 1, 2'b01, 28'h000000A);

    // Shift left x3 by requester 1, sin=1; command inputs changed after grant must be ignored
    cmd1 = 2'b01; cnt1 = 3'd3; sin = 1'b1;
    start("shl", 2'b10, 4'b1010, 2'b10);
    cmd1 = 2'b00; din1 = 4'b1111; cnt1 = 3'd7; sin = 1'b1;
    exec_seq("shl", 3, 2'b10, 28'h00007B5);

    // Shift right x2 by requester 0, sin=0
    cmd0 = 2'b10; cnt0 = 3'd2; sin = 1'b0;
    start("shr", 2'b01, 4'b0111, 2'b01);
    exec_seq("shr", 2, 2'b01, 28'h0000013);

    // Load 1001 by requester 1, then rotate left x4 by requester 0 (sin ignored)
    cmd1 = 2'b00; din1 = 4'b1001;
    start("ld9", 2'b10, 4'b0001, 2'b10);
    exec_seq("ld9", 1, 2'b10, 28'h0000009);
    cmd0 = 2'b11; cnt0 = 3'd4; sin = 1'b1;
    start("rol", 2'b01, 4'b1001, 2'b01);
    exec_seq("rol", 4, 2'b01, 28'h0009C63);

    // Zero shift count: one EXEC cycle, q unchanged
    cmd1 = 2'b01; cnt1 = 3'd0; sin = 1'b1;
    start("cnt0", 2'b10, 4'b1001, 2'b10);
    exec_seq("cnt0", 1, 2'b10, 28'h0000009);

    // Contention after a fresh reset: alternating grants starting at requester 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cmd0 = 2'b00; din0 = 4'b0001;
    cmd1 = 2'b00; din1 = 4'b0010;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("cont%0d_e0", i), (i == 0) ? 4'b0000 : ((i % 2 == 1) ? 4'b0001 : 4'b0010),
              (i % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 1'b0);
      tick();
      chk_out($sformatf("cont%0d_e1", i), (i % 2 == 1) ? 4'b0010 : 4'b0001,
              (i % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 1'b1);
      tick();
      chk_out($sformatf("cont%0d_idle", i), (i % 2 == 1) ? 4'b0010 : 4'b0001,
              2'b00, 1'b0, 1'b0);
    end
    req = 2'b00;

    // Requester 0 served once so the pointer favours requester 1
    cmd0 = 2'b00; din0 = 4'b0110;
    start("ldA", 2'b01, 4'b0010, 2'b01);
    exec_seq("ldA", 1, 2'b01, 28'h0000006);

    // Reset during the second shift of a 5-shift command
    cmd0 = 2'b01; cnt0 = 3'd5; sin = 1'b0;
    start("rstop", 2'b01, 4'b0110, 2'b01);
    tick();
    chk_out("rstop_e1", 4'b1100, 2'b01, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1 chk_out("rstop_async", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("rstop_hold", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    cmd0 = 2'b00; din0 = 4'b1111;
    cmd1 = 2'b00; din1 = 4'b0101;
    start("post_rst", 2'b11, 4'b0000, 2'b01);
    tick();
    chk_out("post_rst_e1", 4'b1111, 2'b01, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shreg_arbiter.md
# shreg_arbiter

Shared-access controller for a 4-bit parallel/universal shift register. Two requesters share the register through a req/gnt handshake with round-robin arbitration. The granted requester issues one command: parallel load, shift left, shift right or rotate left, repeated N times. The block owns the register itself and sequences the command cycle by cycle. It sits between the PIPO/shift-register datapath and the units that need serial or parallel access to it.

## Interface
- WIDTH, 4, register width in bits
- CNTW, 3, width of the shift-count field (max 7 shifts per command)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- req  input  2  request, bit k from requester k; held high until done
- cmd0, cmd1  input  2  command of requester 0/1: 00 load, 01 shift left, 10 shift right, 11 rotate left
- din0, din1  input  WIDTH  parallel load data of requester 0/1
- cnt0, cnt1  input  CNTW  shift count of requester 0/1 (ignored for load)
- sin  input  1  serial input bit, sampled on every shift edge
- gnt  output  2  one-hot grant, registered
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle completion pulse (state DONE)
- q  output  WIDTH  register contents

## Operation
- States: IDLE, EXEC, DONE. Reset value of every output is 0 (q=0, gnt=00, busy=0, done=0), state=IDLE, priority pointer=requester 0.
- IDLE: at a clock edge with req!=00, select a winner.
  - One requester high: it wins.
  - Both high: the pointer's requester wins.
  - On selection: latch its cmd, din and cnt into internal registers, set gnt for the winner, go to EXEC.
- EXEC, load: q<=latched din on the first EXEC edge, then go to DONE.
- EXEC, shifts: one shift per edge, with a remaining-count register decremented each edge; go to DONE on the edge that performs the last shift.
  - Shift left: q<={q[WIDTH-2:0],sin}.
  - Shift right: q<={sin,q[WIDTH-1:1]}.
  - Rotate left: q<={q[WIDTH-2:0],q[WIDTH-1]}; sin ignored.
  - cnt=0 on a shift/rotate: one EXEC cycle, q unchanged, then DONE.
- DONE: done=1 and gnt stays asserted. The next edge goes to IDLE with gnt=00, and the pointer moves to the requester that was not just served.
- req and cmd/din/cnt changes after the grant are ignored; the operation always completes.
- No new grant is issued from DONE. There is at least one IDLE cycle between operations.
- q holds its value in IDLE and DONE.

## Timing
- Edge E0 (IDLE, req seen): gnt and busy high after E0.
- Load: q updated at E1, done high E1–E2, gnt/busy low after E2. Total 3 edges from request.
- Shift count N≥1: q changes at E1..EN, done high after EN, idle after EN+1.
- Back-to-back: a requester that keeps req high after its done is re-granted at the edge after returning to IDLE, provided it wins arbitration.
- Reset mid-operation: asynchronous clear to the reset values. The partially shifted q is lost, and the pointer returns to requester 0.
- Simultaneous req bits at E0 are resolved only by the pointer. A req on the losing bit stays pending and wins the next IDLE arbitration.

## Test plan
- Reset values: hold rst=0 with random inputs -> q=0000, gnt=00, busy=0, done=0. Release rst, req=00 for 5 cycles -> all outputs unchanged.
- Load: req=01, cmd0=00, din0=1010 -> gnt=01 after E0, q=1010 at E1, done pulse of 1 cycle, gnt=00 after E2.
- Shift left: from q=1010, requester 1 cmd1=01, cnt1=3, sin=1 -> q=0101, 1011, 0111 on consecutive edges, then done. Shift right cnt=2, sin=0 from 0111 -> 0011, 0001.
- Rotate: q=1001, cmd=11, cnt=4 -> 0011, 0110, 1100, 1001, then done. cnt=0 -> q unchanged, done after one EXEC cycle.
- Contention: req=11 held continuously after reset -> grants in order 01, 10, 01, 10, each separated by DONE then IDLE.
- Reset mid-op: drive rst low during the 2nd shift of cnt=5 -> immediate q=0000, gnt=00, busy=0. After release, req=11 -> requester 0 is granted first.
